// File: rtl/blk_mem_arbiter.sv
// Shares one backing-memory port between I-cache reads and D-cache reads/writes, one transaction at a time.
// Optional BLK_ARB_RR_EN: round-robin on contention (default: D side has fixed priority over I side).
module blk_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BLK_W  = 256
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              iBlkRead,
  input  logic [ADDR_W-1:0] i_address,
  output logic [BLK_W-1:0]  block_read_fIM,
  output logic              block_read_fIM_valid,
  input  logic              dBlkRead,
  input  logic              dBlkWrite,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [BLK_W-1:0]  block_write_2DM,
  output logic [BLK_W-1:0]  block_read_fDM,
  output logic              block_read_fDM_valid,
  output logic              block_write_fDM_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       cnt_i_rd,
  output logic [31:0]       cnt_d_rd,
  output logic [31:0]       cnt_d_wr
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP, ST_DONE} state_e;

  state_e            state_q;
  logic              gnt_d_q, we_q, abort_q, mem_req_q;
  logic              i_vld_q, d_rd_vld_q, d_wr_vld_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BLK_W-1:0]  mem_wdata_q, fim_q, fdm_q;
  logic [31:0]       cnt_i_rd_q, cnt_d_rd_q, cnt_d_wr_q;

  logic d_any, pick_d, gnt_live;
  logic [9:0] unused_addr_bits;

  assign unused_addr_bits = {i_address[4:0], d_address[4:0]};
  assign d_any = dBlkRead | dBlkWrite;
  // The granted requester still holds its level; dropping it during BUSY aborts the grant.
  assign gnt_live = gnt_d_q ? (we_q ? dBlkWrite : dBlkRead) : iBlkRead;

`ifdef BLK_ARB_RR_EN
  logic last_d_q;

  // On a tie the side that was not served last wins; reset value means "I served last".
  assign pick_d = d_any & (~iBlkRead | ~last_d_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_d_q <= 1'b0;
    end else if (state_q == ST_RESP) begin
      last_d_q <= gnt_d_q;
    end
  end
`else
  assign pick_d = d_any;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      gnt_d_q     <= 1'b0;
      we_q        <= 1'b0;
      abort_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      i_vld_q     <= 1'b0;
      d_rd_vld_q  <= 1'b0;
      d_wr_vld_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fim_q       <= '0;
      fdm_q       <= '0;
      cnt_i_rd_q  <= '0;
      cnt_d_rd_q  <= '0;
      cnt_d_wr_q  <= '0;
    end else begin
      i_vld_q    <= 1'b0;
      d_rd_vld_q <= 1'b0;
      d_wr_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iBlkRead | d_any) begin
            gnt_d_q    <= pick_d;
            we_q       <= pick_d & dBlkWrite;
            abort_q    <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pick_d ? {d_address[ADDR_W-1:5], 5'b0}
                                 : {i_address[ADDR_W-1:5], 5'b0};
            if (pick_d & dBlkWrite) mem_wdata_q <= block_write_2DM;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!gnt_live) abort_q <= 1'b1;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RESP;
            if (!we_q) begin
              if (gnt_d_q) fdm_q <= mem_rdata;
              else         fim_q <= mem_rdata;
            end
            // Strobe and counter become visible together in the RESP cycle.
            if (!abort_q && gnt_live) begin
              if (!gnt_d_q) begin
                i_vld_q    <= 1'b1;
                cnt_i_rd_q <= cnt_i_rd_q + 32'd1;
              end else if (we_q) begin
                d_wr_vld_q <= 1'b1;
                cnt_d_wr_q <= cnt_d_wr_q + 32'd1;
              end else begin
                d_rd_vld_q <= 1'b1;
                cnt_d_rd_q <= cnt_d_rd_q + 32'd1;
              end
            end
          end
        end
        ST_RESP: state_q <= ST_DONE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign block_read_fIM        = fim_q;
  assign block_read_fIM_valid  = i_vld_q;
  assign block_read_fDM        = fdm_q;
  assign block_read_fDM_valid  = d_rd_vld_q;
  assign block_write_fDM_valid = d_wr_vld_q;
  assign mem_req               = mem_req_q;
  assign mem_we                = we_q;
  assign mem_addr              = mem_addr_q;
  assign mem_wdata             = mem_wdata_q;
  assign cnt_i_rd              = cnt_i_rd_q;
  assign cnt_d_rd              = cnt_d_rd_q;
  assign cnt_d_wr              = cnt_d_wr_q;

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// Scoreboard bench for blk_mem_arbiter; the contention order follows BLK_ARB_RR_EN.
module tb_blk_mem_arbiter;

  localparam logic [1:0] K_IRD = 2'd0;
  localparam logic [1:0] K_DRD = 2'd1;
  localparam logic [1:0] K_DWR = 2'd2;

  typedef struct {
    logic [1:0]   kind;
    logic [31:0]  addr;
    logic [255:0] data;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         iBlkRead = 1'b0, dBlkRead = 1'b0, dBlkWrite = 1'b0, mem_ack = 1'b0;
  logic [31:0]  i_address = '0, d_address = '0;
  logic [255:0] block_write_2DM = '0, mem_rdata = '0;
  logic [255:0] block_read_fIM, block_read_fDM, mem_wdata;
  logic         block_read_fIM_valid, block_read_fDM_valid, block_write_fDM_valid;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, cnt_i_rd, cnt_d_rd, cnt_d_wr;

  int           vectors = 0;
  int           miscompares = 0;
  exp_t         exp_q[$];
  logic [31:0]  exp_ci = '0, exp_cdr = '0, exp_cdw = '0;
  logic [255:0] exp_fim = '0, exp_fdm = '0;

  blk_mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .iBlkRead(iBlkRead), .i_address(i_address),
    .block_read_fIM(block_read_fIM), .block_read_fIM_valid(block_read_fIM_valid),
    .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite), .d_address(d_address),
    .block_write_2DM(block_write_2DM),
    .block_read_fDM(block_read_fDM), .block_read_fDM_valid(block_read_fDM_valid),
    .block_write_fDM_valid(block_write_fDM_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cnt_i_rd(cnt_i_rd), .cnt_d_rd(cnt_d_rd), .cnt_d_wr(cnt_d_wr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [255:0] pat(input logic [31:0] seed);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = seed + 32'(i * 32'h0101_0101);
    return p;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Holds ack for one cycle starting n cycles from now; returns in the strobe cycle.
  task automatic ack_after(input int n, input logic [255:0] data);
    repeat (n) @(negedge CLK);
    mem_rdata = data;
    mem_ack   = 1'b1;
    @(negedge CLK);
    mem_ack   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_ci = '0; exp_cdr = '0; exp_cdw = '0; exp_fim = '0; exp_fdm = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 256'd0) begin
      miscompares++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, need 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    vectors++;
    if ({block_read_fIM_valid, block_read_fDM_valid, block_write_fDM_valid} !== 3'b000 ||
        block_read_fIM !== 256'd0 || block_read_fDM !== 256'd0) begin
      miscompares++;
      $display("FAIL reset_resp: strobes=%b fim=%h fdm=%h, need 0",
               {block_read_fIM_valid, block_read_fDM_valid, block_write_fDM_valid}, block_read_fIM, block_read_fDM);
    end
    vectors++;
    if (cnt_i_rd !== 32'd0 || cnt_d_rd !== 32'd0 || cnt_d_wr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: %h %h %h, need 0", cnt_i_rd, cnt_d_rd, cnt_d_wr);
    end
  endtask

  task automatic test_i_read();
    exp_t e;
    bit ok;
    e.kind = K_IRD; e.addr = 32'h0040_0000; e.data = {32{8'hA5}};
    exp_q.push_back(e);
    iBlkRead = 1'b1; i_address = 32'h0040_001C;
    wait_req(ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || mem_addr !== e.addr || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL i_read_req: ok=%0d addr=%h we=%b, need addr=%h we=0", ok, mem_addr, mem_we, e.addr);
    end
    ack_after(3, e.data);
    iBlkRead = 1'b0;
    exp_ci++; exp_fim = e.data;
    vectors++;
    if (block_read_fIM_valid !== 1'b1 || block_read_fIM !== e.data) begin
      miscompares++;
      $display("FAIL i_read_data: vld=%b data=%h, need vld=1 data=%h", block_read_fIM_valid, block_read_fIM, e.data);
    end
    @(negedge CLK);
    vectors++;
    if (block_read_fIM_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL i_read_pulse: vld=%b in DONE, need 0", block_read_fIM_valid);
    end
    @(negedge CLK);
    vectors++;
    if (cnt_i_rd !== exp_ci || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL i_read_cnt: cnt=%h req=%b, need cnt=%h req=0", cnt_i_rd, mem_req, exp_ci);
    end
  endtask

  task automatic test_d_write();
    exp_t e;
    bit ok;
    e.kind = K_DWR; e.addr = 32'h1000_0020; e.data = pat(32'hDEAD_0000);
    exp_q.push_back(e);
    dBlkWrite = 1'b1; d_address = 32'h1000_0020; block_write_2DM = e.data;
    wait_req(ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || mem_addr !== e.addr || mem_we !== 1'b1 || mem_wdata !== e.data) begin
      miscompares++;
      $display("FAIL d_write_req: ok=%0d addr=%h we=%b wdata=%h, need addr=%h we=1 wdata=%h",
               ok, mem_addr, mem_we, mem_wdata, e.addr, e.data);
    end
    ack_after(1, pat(32'h7777_0000));
    dBlkWrite = 1'b0;
    exp_cdw++;
    vectors++;
    if (block_write_fDM_valid !== 1'b1 || block_read_fDM_valid !== 1'b0 || block_read_fDM !== exp_fdm) begin
      miscompares++;
      $display("FAIL d_write_resp: wvld=%b rvld=%b fdm=%h, need wvld=1 rvld=0 fdm=%h",
               block_write_fDM_valid, block_read_fDM_valid, block_read_fDM, exp_fdm);
    end
    @(negedge CLK);
    vectors++;
    if (block_write_fDM_valid !== 1'b0 || cnt_d_wr !== exp_cdw) begin
      miscompares++;
      $display("FAIL d_write_cnt: wvld=%b cnt=%h, need wvld=0 cnt=%h", block_write_fDM_valid, cnt_d_wr, exp_cdw);
    end
    @(negedge CLK);
  endtask

  task automatic test_abort();
    bit ok;
    iBlkRead = 1'b1; i_address = 32'h0050_0000;
    wait_req(ok);
    @(negedge CLK);
    iBlkRead = 1'b0;
    @(negedge CLK);
    vectors++;
    if (!ok || mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_hold: ok=%0d req=%b, need req=1 until ack", ok, mem_req);
    end
    ack_after(0, pat(32'h0BAD_0000));
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (block_read_fIM_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_strobe: vld=%b at cycle %0d after ack, need 0", block_read_fIM_valid, i);
      end
      @(negedge CLK);
    end
    vectors++;
    if (cnt_i_rd !== exp_ci || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_cnt: cnt=%h req=%b, need cnt=%h req=0", cnt_i_rd, mem_req, exp_ci);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    iBlkRead = 1'b1; i_address = 32'h2000_0040;
    wait_req(ok);
    @(negedge CLK);
    RESET = 1'b1; iBlkRead = 1'b0;
    #1;
    vectors++;
    if (!ok || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: ok=%0d req=%b, need req=0 immediately", ok, mem_req);
    end
    @(negedge CLK);
    RESET = 1'b0;
    exp_ci = '0; exp_cdr = '0; exp_cdw = '0; exp_fim = '0; exp_fdm = '0;
    vectors++;
    if (mem_addr !== 32'd0 || mem_wdata !== 256'd0 || block_read_fIM !== 256'd0 || block_read_fDM !== 256'd0 ||
        cnt_i_rd !== 32'd0 || cnt_d_rd !== 32'd0 || cnt_d_wr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_vals: addr=%h cnt=%h/%h/%h fim=%h", mem_addr, cnt_i_rd, cnt_d_rd, cnt_d_wr, block_read_fIM);
    end
    ack_after(1, pat(32'h5A5A_0000));
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem_req !== 1'b0 || block_read_fIM_valid !== 1'b0 || block_read_fIM !== 256'd0 || cnt_i_rd !== 32'd0) begin
        miscompares++;
        $display("FAIL stale_ack: req=%b vld=%b fim=%h cnt=%h, need all 0", mem_req, block_read_fIM_valid, block_read_fIM, cnt_i_rd);
      end
      @(negedge CLK);
    end
    e.kind = K_IRD; e.addr = 32'h2000_0040; e.data = pat(32'h1234_5678);
    exp_q.push_back(e);
    iBlkRead = 1'b1; i_address = 32'h2000_005F;
    wait_req(ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || mem_addr !== e.addr) begin
      miscompares++;
      $display("FAIL fresh_req: ok=%0d addr=%h, need %h", ok, mem_addr, e.addr);
    end
    ack_after(0, e.data);
    iBlkRead = 1'b0;
    exp_ci++; exp_fim = e.data;
    vectors++;
    if (block_read_fIM_valid !== 1'b1 || block_read_fIM !== e.data || cnt_i_rd !== exp_ci) begin
      miscompares++;
      $display("FAIL fresh_resp: vld=%b data=%h cnt=%h, need vld=1 data=%h cnt=%h",
               block_read_fIM_valid, block_read_fIM, cnt_i_rd, e.data, exp_ci);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_contention();
    exp_t e, d1, d2, ir;
    bit ok;
    pulse_reset();
    d1.kind = K_DRD; d1.addr = 32'h3000_0000; d1.data = pat(32'hD100_0000);
    ir.kind = K_IRD; ir.addr = 32'h3100_0040; ir.data = pat(32'h1100_0000);
    d2.kind = K_DRD; d2.addr = 32'h3200_0080; d2.data = pat(32'hD200_0000);
    exp_q.push_back(d1);
`ifdef BLK_ARB_RR_EN
    exp_q.push_back(ir);
    exp_q.push_back(d2);
`else
    exp_q.push_back(d2);
    exp_q.push_back(ir);
`endif
    iBlkRead = 1'b1; i_address = ir.addr;
    dBlkRead = 1'b1; d_address = d1.addr;
    for (int r = 0; r < 3; r++) begin
      wait_req(ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || mem_addr !== e.addr || mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL contend_grant%0d: ok=%0d addr=%h we=%b, need addr=%h we=0", r, ok, mem_addr, mem_we, e.addr);
      end
      if (!ok) break;
      ack_after(1, e.data);
      vectors++;
      if (e.kind == K_IRD) begin
        iBlkRead = 1'b0; exp_ci++; exp_fim = e.data;
        if (block_read_fIM_valid !== 1'b1 || block_read_fDM_valid !== 1'b0 || block_read_fIM !== e.data) begin
          miscompares++;
          $display("FAIL contend_resp%0d: ivld=%b dvld=%b fim=%h, need I strobe data=%h",
                   r, block_read_fIM_valid, block_read_fDM_valid, block_read_fIM, e.data);
        end
      end else begin
        dBlkRead = 1'b0; exp_cdr++; exp_fdm = e.data;
        if (block_read_fDM_valid !== 1'b1 || block_read_fIM_valid !== 1'b0 || block_read_fDM !== e.data) begin
          miscompares++;
          $display("FAIL contend_resp%0d: dvld=%b ivld=%b fdm=%h, need D strobe data=%h",
                   r, block_read_fDM_valid, block_read_fIM_valid, block_read_fDM, e.data);
        end
      end
      @(negedge CLK);
      if (r == 0) begin
        dBlkRead = 1'b1; d_address = d2.addr;
      end
    end
    @(negedge CLK);
    vectors++;
    if (cnt_i_rd !== exp_ci || cnt_d_rd !== exp_cdr || block_read_fIM !== exp_fim || block_read_fDM !== exp_fdm) begin
      miscompares++;
      $display("FAIL contend_cnt: i=%h d=%h, need i=%h d=%h", cnt_i_rd, cnt_d_rd, exp_ci, exp_cdr);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    bit ok;
    @(negedge CLK);
    force dut.cnt_d_rd_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_d_rd_q;
    exp_cdr = 32'hFFFF_FFFF;
    @(negedge CLK);
    vectors++;
    if (cnt_d_rd !== exp_cdr) begin
      miscompares++;
      $display("FAIL wrap_preload: cnt=%h, need %h", cnt_d_rd, exp_cdr);
    end
    e.kind = K_DRD; e.addr = 32'h4000_0000; e.data = pat(32'hCAFE_0000);
    exp_q.push_back(e);
    dBlkRead = 1'b1; d_address = 32'h4000_0004;
    wait_req(ok);
    e = exp_q.pop_front();
    ack_after(2, e.data);
    dBlkRead = 1'b0;
    exp_cdr = exp_cdr + 32'd1;
    vectors++;
    if (!ok || block_read_fDM_valid !== 1'b1 || block_read_fDM !== e.data) begin
      miscompares++;
      $display("FAIL wrap_resp: ok=%0d vld=%b data=%h, need vld=1 data=%h", ok, block_read_fDM_valid, block_read_fDM, e.data);
    end
    repeat (2) @(negedge CLK);
    vectors++;
    if (cnt_d_rd !== exp_cdr) begin
      miscompares++;
      $display("FAIL wrap_cnt: cnt=%h, need %h", cnt_d_rd, exp_cdr);
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_abort();
    test_reset_mid();
    test_contention();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blk_mem_arbiter.md
# blk_mem_arbiter

Arbitrates 256-bit cache-block traffic from the instruction cache and data cache onto one shared backing-memory port. It sits directly downstream of the `MIPS` core and consumes its `iBlkRead`, `dBlkRead`, `dBlkWrite`, `Instr_address_2IM`, `data_address_2DM` and `block_write_2DM` outputs. It returns `block_read_fIM`, `block_read_fDM` and the matching valid strobes. One transaction is outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.
- `BLK_W`, default 256: block width in bits; the block is 32 bytes, so address bits [4:0] are ignored.

Ports:
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `iBlkRead` in 1: I-cache block read request; level, held until the valid strobe.
- `i_address` in ADDR_W: I-cache block address.
- `block_read_fIM` out BLK_W: I-side read data.
- `block_read_fIM_valid` out 1: one-cycle I-side completion strobe.
- `dBlkRead` / `dBlkWrite` in 1: D-cache read and write requests; level, held until the strobe.
- `d_address` in ADDR_W: D-cache block address.
- `block_write_2DM` in BLK_W: D-cache write data.
- `block_read_fDM` out BLK_W: D-side read data.
- `block_read_fDM_valid` / `block_write_fDM_valid` out 1: one-cycle D-side completion strobes.
- `mem_req` out 1: backing-memory request, held until `mem_ack`.
- `mem_we` out 1: 1 selects write, 0 selects read.
- `mem_addr` out ADDR_W: block-aligned address, {addr[ADDR_W-1:5], 5'b0}.
- `mem_wdata` out BLK_W: write data.
- `mem_rdata` in BLK_W: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: completion of the current memory transaction.
- `cnt_i_rd` / `cnt_d_rd` / `cnt_d_wr` out 32: completed-transaction counters.

## Operation
States:
- IDLE: no request granted. If any request is pending, latch the grant, address, write data and `mem_we`, then go to BUSY.
- BUSY: `mem_req` is 1. When `mem_ack` is 1, register `mem_rdata` if the transaction is a read, then go to RESP.
- RESP: pulse the strobe of the granted requester for exactly one cycle, then go to DONE.
- DONE: one-cycle hold-off with no grant, so the requester can drop its level. Then go to IDLE.

Rules:
- Read data outputs hold their last captured value until the next capture on the same side.
- `dBlkRead` and `dBlkWrite` asserted together is a protocol violation. The write is served and the read is ignored for that grant.
- Abort: if the granted requester drops its request during BUSY, the memory transaction still completes. The strobe is suppressed and the counter is not incremented.
- Counters increment by 1 in the RESP cycle of an unaborted transaction. They wrap modulo 2^32.
- Reset mid-transaction: all state clears immediately and `mem_req` drops. Any in-flight memory transaction is abandoned, and a later stale `mem_ack` seen in IDLE or DONE is ignored.
- Reset values: state IDLE; `mem_req`, `mem_we` and all strobes 0; `mem_addr`, `mem_wdata`, both read data buses and all counters 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Request sampled in IDLE at cycle 0 → `mem_req` = 1 at cycle 1.
- `mem_ack` sampled at cycle k → strobe and data at cycle k+1 → DONE at k+2 → IDLE at k+3.
- Minimum occupancy per transaction is 4 cycles, reached when `mem_ack` arrives in cycle 1.
- A request still held in IDLE is regranted, so requesters must deassert no later than the DONE cycle.

## Configuration
- `BLK_ARB_RR_EN` defined: round-robin arbitration. A 1-bit last-served flag is updated in RESP, and when both sides request, the side not served last wins. The flag resets to "I served last", so D wins the first tie.
- `BLK_ARB_RR_EN` undefined: fixed priority, D side over I side. The last-served flag is not built.

## Test plan
- I read, `mem_ack` 3 cycles after `mem_req`, `mem_rdata` = 256'hA5…A5, `i_address` = 0x0040_001C:
  - `mem_addr` = 0x0040_0000 and `mem_we` = 0.
  - `block_read_fIM_valid` is high for one cycle and `block_read_fIM` = A5…A5.
  - `cnt_i_rd` = 1.
- D write to 0x1000_0020 with pattern data: `mem_we` = 1 and `mem_wdata` equals the input; `block_write_fDM_valid` pulses once; `cnt_d_wr` = 1; `block_read_fDM` is unchanged.
- I and D requests asserted in the same cycle, held until served:
  - Without the macro: D is granted first, then I after DONE.
  - With the macro: two back-to-back contested rounds alternate D, I.
- Abort: `iBlkRead` drops during BUSY → `mem_req` stays high until ack; no `block_read_fIM_valid`; `cnt_i_rd` is unchanged.
- `RESET` pulsed mid-BUSY, then `mem_ack` arrives 2 cycles later → all outputs read their reset values; the stale ack is ignored; a fresh I read afterwards completes normally.
- Preload `cnt_d_rd` to 0xFFFF_FFFF through a force, then complete one D read → `cnt_d_rd` = 0.
